apb_master_bridge: RTL

- APB4 requester: turns a simple valid/ready command port into APB SETUP/ACCESS transfers.
- Returns one response per command: read data, slave error, timeout.
- Sits in front of the APB slave under test; it is the initiating end of the same bus.
- Used as the synthesizable stimulus source and as the reference requester in integration benches.

---
 rtl/apb_master_bridge.sv | 84 ++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready command port to APB4 requester with per-command
// response and optional ACCESS-phase timeout.
module apb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH/8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [STRB_WIDTH-1:0] pstrb,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);
  // The counter only has to reach TIMEOUT_CYCLES-1: the cycle at that count either completes or aborts.
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic accept, done, expire;
  assign cmd_ready = state == IDLE || (state == ACCESS && pready);
  assign accept = cmd_valid && cmd_ready;
  assign done = state == ACCESS && pready;
  assign expire = TIMEOUT_CYCLES != 0 && state == ACCESS && !pready && cnt == LAST;
  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      cnt         <= '0;
      paddr       <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= done || expire;
      if (done || expire) begin
        rsp_err     <= expire || pslverr;
        rsp_timeout <= expire;
        rsp_rdata   <= (expire || pwrite) ? '0 : prdata;
      end
      if (accept) begin
        state   <= SETUP;
        cnt     <= '0;
        psel    <= 1'b1;
        penable <= 1'b0;
        paddr   <= cmd_addr;
        pwrite  <= cmd_write;
        pwdata  <= cmd_wdata;
        pstrb   <= cmd_write ? cmd_strb : '0;
      end else if (state == SETUP) begin
        state   <= ACCESS;
        penable <= 1'b1;
      end else if (done || expire) begin
        state   <= IDLE;
        psel    <= 1'b0;
        penable <= 1'b0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule
